// File: rtl/button_press_classifier_if.sv
// Event bus between the debounced edge detector / application logic and the classifier.
// The classifier is the slave: it consumes rise/fall and drives the event pulses.
interface button_press_classifier_if;
    logic rise;
    logic fall;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic double_click;
    logic held;

    modport master (
        output rise,
        output fall,
        input  short_press,
        input  long_press,
        input  repeat_pulse,
        input  double_click,
        input  held
    );

    modport slave (
        input  rise,
        input  fall,
        output short_press,
        output long_press,
        output repeat_pulse,
        output double_click,
        output held
    );
endinterface

// File: rtl/button_press_classifier.sv
// Classifies one active-high button's press/release pulses into short, long, repeat and
// double-click one-cycle events, plus a registered "held" level.
module button_press_classifier #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int GAP_CYCLES    = 12_500_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    button_press_classifier_if.slave     bus
);
    localparam int MAX_LG   = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int MAX_LGR  = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int MAX_ALL  = (MAX_LGR > 2) ? MAX_LGR : 2;
    localparam int CNT_W    = $clog2(MAX_ALL);

    localparam bit                 REP_EN    = (REPEAT_CYCLES != 0);
    localparam int                 REP_LAST_I = REP_EN ? (REPEAT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0]   LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REP_LAST  = CNT_W'(REP_LAST_I);

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_short;
    logic             r_long;
    logic             r_repeat;
    logic             r_double;
    logic             r_held;

    // Simultaneous rise and fall are contradictory, so both are dropped.
    logic w_rise;
    logic w_fall;
    assign w_rise = bus.rise & ~bus.fall;
    assign w_fall = bus.fall & ~bus.rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_double <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_double <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                        r_held  <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (w_fall) begin
                        r_state <= ST_WAIT_SECOND;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end else if (r_cnt == LONG_LAST) begin
                        r_state <= ST_LONG_HELD;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_LONG_HELD: begin
                    // A release on a would-be repeat edge wins and suppresses that repeat.
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end else if (REP_EN && (r_cnt == REP_LAST)) begin
                        r_repeat <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_SECOND: begin
                    if (w_rise) begin
                        r_state <= ST_SECOND_PRESSED;
                        r_cnt   <= '0;
                        r_held  <= 1'b1;
                    end else if (r_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_short <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SECOND_PRESSED: begin
                    if (w_fall) begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_double <= 1'b1;
                        r_held   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.short_press  = r_short;
    assign bus.long_press   = r_long;
    assign bus.repeat_pulse = r_repeat;
    assign bus.double_click = r_double;
    assign bus.held         = r_held;
endmodule
